// File: rtl/dot8_accum.sv
// Sequential 8x8 dot-product engine: LEN operand pairs in, one ACC_W-bit sum out.
// Define DOT8_ACC_SAT_EN to saturate the accumulator instead of wrapping.

module multiplier8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = a * b;
endmodule

module dot8_accum #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             overflow
);

  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

  localparam logic [7:0] LAST = 8'(LEN - 1);

  state_t             state_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [7:0]         cnt_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [15:0]        p_q_reg;
  logic               pv_reg;
  logic               first_reg;
  logic               overflow_reg;

  logic [15:0]        product;
  logic [ACC_W:0]     add_wide;
  logic               accept;

  multiplier8 u_mult (
    .a (a),
    .b (b),
    .p (product)
  );

  assign accept   = in_valid && in_ready_reg;
  // One extra bit captures the carry-out of the accumulator addition.
  assign add_wide = {1'b0, acc_reg} + (ACC_W+1)'(p_q_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ACCUM;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      p_q_reg       <= '0;
      pv_reg        <= 1'b0;
      first_reg     <= 1'b1;
      overflow_reg  <= 1'b0;
    end else if (sclr) begin
      state_reg     <= ACCUM;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      p_q_reg       <= '0;
      pv_reg        <= 1'b0;
      first_reg     <= 1'b1;
      overflow_reg  <= 1'b0;
    end else begin
      pv_reg <= accept;
      if (accept) begin
        p_q_reg <= product;
      end

      if (pv_reg) begin
        first_reg <= 1'b0;
        if (first_reg) begin
          acc_reg <= ACC_W'(p_q_reg);
        end else begin
          if (add_wide[ACC_W]) begin
            overflow_reg <= 1'b1;
          end
`ifdef DOT8_ACC_SAT_EN
          // Once clamped, further additions keep carrying, so acc stays pinned.
          acc_reg <= add_wide[ACC_W] ? '1 : add_wide[ACC_W-1:0];
`else
          acc_reg <= add_wide[ACC_W-1:0];
`endif
        end
      end

      unique case (state_reg)
        ACCUM: begin
          if (accept) begin
            cnt_reg <= cnt_reg + 8'd1;
            if (cnt_reg == LAST) begin
              state_reg    <= DRAIN;
              in_ready_reg <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (pv_reg) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= ACCUM;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            pv_reg        <= 1'b0;
            first_reg     <= 1'b1;
            overflow_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ACCUM;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sum       = acc_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_dot8_accum.sv
// Randomised self-checking bench for dot8_accum: three instances (LEN/ACC_W variants)
// share stimulus; each test selects which instance it observes.

module tb_dot8_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       out_ready = 1'b1;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic        vld0, vld1, vld2;
  logic [23:0] sum0;
  logic [16:0] sum1;
  logic [23:0] sum2;

  int          sel = 0;
  int          cur_w = 24;
  logic        m_in_ready, m_out_valid, m_ov;
  logic [31:0] m_sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int pa[$];
  int pb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dot8_accum #(.LEN(4), .ACC_W(24)) dut0 (
    .clk(clk), .rst(rst), .sclr(sclr), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .out_valid(vld0), .out_ready(out_ready), .sum(sum0), .overflow(ov0));
  dot8_accum #(.LEN(4), .ACC_W(17)) dut1 (
    .clk(clk), .rst(rst), .sclr(sclr), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .out_valid(vld1), .out_ready(out_ready), .sum(sum1), .overflow(ov1));
  dot8_accum #(.LEN(1), .ACC_W(24)) dut2 (
    .clk(clk), .rst(rst), .sclr(sclr), .in_valid(in_valid), .in_ready(rdy2),
    .a(a), .b(b), .out_valid(vld2), .out_ready(out_ready), .sum(sum2), .overflow(ov2));

  always_comb begin
    m_in_ready  = rdy0;
    m_out_valid = vld0;
    m_ov        = ov0;
    m_sum       = {8'd0, sum0};
    case (sel)
      1: begin m_in_ready = rdy1; m_out_valid = vld1; m_ov = ov1; m_sum = {15'd0, sum1}; end
      2: begin m_in_ready = rdy2; m_out_valid = vld2; m_ov = ov2; m_sum = {8'd0, sum2}; end
      default: ;
    endcase
  end

  task automatic sync_clear();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
  endtask

  task automatic send(input int x, input int y, input int gap_max);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) @(negedge clk);
    in_valid = 1'b1;
    a = 8'(x);
    b = 8'(y);
    for (int i = 0; i < 50; i++) begin
      if (m_in_ready) begin
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        last_acc = cyc;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready got 0 required 1 within 50 cycles");
  endtask

  // Drives pa/pb as one batch; expectation comes from plain-integer arithmetic.
  task automatic run_batch(input int gap_max, input int hold, input string name);
    longint total, maxv, exp_sum;
    logic   exp_ov;
    logic [31:0] held;
    total = 0;
    foreach (pa[i]) total += longint'(pa[i] * pb[i]);
    maxv = (longint'(1) << cur_w) - 1;
`ifdef DOT8_ACC_SAT_EN
    exp_sum = (total > maxv) ? maxv : total;
`else
    exp_sum = total & maxv;
`endif
    exp_ov = (total > maxv);
    out_ready = (hold == 0);
    foreach (pa[i]) send(pa[i], pb[i], gap_max);
    for (int i = 0; i < 20 && !m_out_valid; i++) @(negedge clk);
    checks++;
    if (m_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid_timeout: out_valid got %0b required 1", name, m_out_valid);
      out_ready = 1'b1;
      return;
    end
    checks++;
    if (cyc - last_acc !== 1) begin
      errors++;
      $display("FAIL %s_latency: out_valid after %0d edges past accept edge, required 1", name, cyc - last_acc);
    end
    checks++;
    if (m_sum !== 32'(exp_sum)) begin
      errors++;
      $display("FAIL %s_sum: got %0d required %0d", name, m_sum, exp_sum);
    end
    checks++;
    if (m_ov !== exp_ov) begin
      errors++;
      $display("FAIL %s_overflow: got %0b required %0b", name, m_ov, exp_ov);
    end
    $display("batch %s: sum %0d overflow %0b (model %0d/%0b)", name, m_sum, m_ov, exp_sum, exp_ov);
    held = m_sum;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a = 8'd9;
      b = 8'd9;
      @(negedge clk);
      checks++;
      if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0 || m_sum !== held) begin
        errors++;
        $display("FAIL %s_hold: valid %0b ready %0b sum %0d required 1 0 %0d",
                 name, m_out_valid, m_in_ready, m_sum, held);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_consume: valid %0b ready %0b required 0 1", name, m_out_valid, m_in_ready);
    end
  endtask

  task automatic set_pairs(input int x, input int y, input int n);
    pa.delete();
    pb.delete();
    for (int i = 0; i < n; i++) begin
      pa.push_back(x);
      pb.push_back(y);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    cur_w = 24;
    repeat (2) @(negedge clk);
    checks++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_sum !== 32'd0 || m_ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ready %0b valid %0b sum %0d ov %0b required 1 0 0 0",
               m_in_ready, m_out_valid, m_sum, m_ov);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready %0b valid %0b required 1 0", m_in_ready, m_out_valid);
    end
  endtask

  task automatic test_basic();
    sel = 0;
    cur_w = 24;
    sync_clear();
    pa = '{66, 120, 8, 255};
    pb = '{61, 240, 8, 255};
    run_batch(0, 0, "basic");
  endtask

  task automatic test_backpressure();
    sel = 0;
    cur_w = 24;
    sync_clear();
    pa = '{66, 120, 8, 255};
    pb = '{61, 240, 8, 255};
    run_batch(2, 5, "backpressure");
    set_pairs(1, 1, 4);
    run_batch(0, 0, "after_done_offer");
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      cur_w = (s == 1) ? 17 : 24;
      sync_clear();
      for (int k = 0; k < 6; k++) begin
        pa.delete();
        pb.delete();
        for (int i = 0; i < ((s == 2) ? 1 : 4); i++) begin
          pa.push_back(int'($urandom_range(255, 0)));
          pb.push_back(int'($urandom_range(255, 0)));
        end
        run_batch(2, int'($urandom_range(3, 0)), "random");
      end
    end
  endtask

  task automatic test_overflow();
    sel = 1;
    cur_w = 17;
    sync_clear();
    set_pairs(255, 255, 4);
    run_batch(0, 0, "overflow");
    set_pairs(2, 3, 4);
    run_batch(0, 0, "post_overflow");
  endtask

  task automatic test_sclr();
    sel = 0;
    cur_w = 24;
    sync_clear();
    send(10, 10, 0);
    send(20, 20, 0);
    in_valid = 1'b1;
    a = 8'd5;
    b = 8'd5;
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_sum !== 32'd0 || m_ov !== 1'b0) begin
      errors++;
      $display("FAIL sclr_state: ready %0b valid %0b sum %0d ov %0b required 1 0 0 0",
               m_in_ready, m_out_valid, m_sum, m_ov);
    end
    set_pairs(1, 2, 4);
    run_batch(0, 0, "after_sclr");
  endtask

  task automatic test_async_reset();
    sel = 0;
    cur_w = 24;
    sync_clear();
    for (int i = 0; i < 4; i++) send(50, 50, 0);
    checks++;
    if (m_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_ready: in_ready got %0b required 0", m_in_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_sum !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: ready %0b valid %0b sum %0d required 1 0 0",
               m_in_ready, m_out_valid, m_sum);
    end
    @(negedge clk);
    rst = 1'b0;
    set_pairs(3, 3, 4);
    run_batch(0, 0, "after_reset");
  endtask

  task automatic test_len1();
    sel = 2;
    cur_w = 24;
    sync_clear();
    set_pairs(200, 100, 1);
    run_batch(0, 0, "len1_a");
    set_pairs(7, 9, 1);
    run_batch(0, 0, "len1_b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_sclr();
    test_async_reset();
    test_len1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
